// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC sequencer and the wrapper-side benches.
// Lane i of a packed x/w group occupies bits [i*bw +: bw].
package mac_seq_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int LANES = 4;
endpackage

// File: rtl/mac_seq_fsm.sv
// Job sequencing for the MAC sequencer: group counting, capture timing and handshakes.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// RUN   | accepting groups, capturing the wrapper output one cycle after each beat
// DONE  | result held with result_valid high until result_ready
module mac_seq_fsm
   import mac_seq_pkg::*;
#(
   parameter int len_bw = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [len_bw-1:0] num_groups,
   input  logic              in_valid,
   input  logic              result_ready,
   output logic              in_ready,
   output logic              result_valid,
   output logic              busy,
   output logic              job_start,
   output logic              accept,
   output logic              capture,
   output logic              final_capture
);

   state_e            state_q, state_d;
   logic [len_bw-1:0] count_q;
   logic [len_bw-1:0] ng_q;
   logic              pend_q;

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d       = state_q;
      in_ready      = 1'b0;
      result_valid  = 1'b0;
      job_start     = 1'b0;
      accept        = 1'b0;
      capture       = 1'b0;
      final_capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               job_start = 1'b1;
               state_d   = (num_groups == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            in_ready = (count_q < ng_q);
            accept   = in_valid & in_ready;
            capture  = pend_q;
            // The last beat's product is only visible in the cycle after it was registered.
            if ((count_q == ng_q) && pend_q && !accept) begin
               final_capture = 1'b1;
               state_d       = DONE;
            end
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         ng_q    <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (job_start) begin
            count_q <= '0;
            ng_q    <= num_groups;
            pend_q  <= 1'b0;
         end else if (state_q == RUN) begin
            pend_q <= accept;
            if (accept) count_q <= count_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Drives the 4-lane dot-product MAC wrapper from a group stream and folds its
// combinational output back into an accumulator, returning the final sum.
module mac_seq_ctrl
   import mac_seq_pkg::*;
#(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int len_bw  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [len_bw-1:0]     num_groups,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*bw-1:0]   x_in,
   input  logic [LANES*bw-1:0]   w_in,
   output logic [LANES*bw-1:0]   x_out,
   output logic [LANES*bw-1:0]   w_out,
   output logic [psum_bw-1:0]    psum_out,
   input  logic [psum_bw-1:0]    mac_out,
   output logic [psum_bw-1:0]    result,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic                  busy
);

   logic               job_start;
   logic               accept;
   logic               capture;
   logic               final_capture;
   logic [psum_bw-1:0] acc;

   mac_seq_fsm #(
      .len_bw(len_bw)
   ) u_fsm (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_groups   (num_groups),
      .in_valid     (in_valid),
      .result_ready (result_ready),
      .in_ready     (in_ready),
      .result_valid (result_valid),
      .busy         (busy),
      .job_start    (job_start),
      .accept       (accept),
      .capture      (capture),
      .final_capture(final_capture)
   );

   assign psum_out = acc;

   // mac_out already equals acc + dot(x_out, w_out), so capture is a plain load.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_out  <= '0;
         w_out  <= '0;
         acc    <= '0;
         result <= '0;
      end else begin
         if (accept) begin
            x_out <= x_in;
            w_out <= w_in;
         end
         if (job_start)    acc <= '0;
         else if (capture) acc <= mac_out;
         if (job_start)          result <= '0;
         else if (final_capture) result <= mac_out;
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural model of the combinational MAC wrapper.
module tb_mac_seq_ctrl;
   localparam int BW = 4;
   localparam int PSUM_BW = 16;
   localparam int LEN_BW = 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic [LEN_BW-1:0] num_groups;
   logic              in_valid;
   logic              in_ready;
   logic [4*BW-1:0]   x_in, w_in, x_out, w_out;
   logic [PSUM_BW-1:0] psum_out, mac_out, result;
   logic              result_valid;
   logic              result_ready;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int accept_cnt = 0;

   mac_seq_ctrl #(.bw(BW), .psum_bw(PSUM_BW), .len_bw(LEN_BW)) dut (
      .clk(clk), .reset(reset), .start(start), .num_groups(num_groups),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
      .x_out(x_out), .w_out(w_out), .psum_out(psum_out), .mac_out(mac_out),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Wrapper model: unsigned lanes, sum wraps at psum width.
   always_comb begin
      mac_out = psum_out;
      for (int i = 0; i < 4; i++)
         mac_out = mac_out + PSUM_BW'(x_out[i*BW +: BW]) * PSUM_BW'(w_out[i*BW +: BW]);
   end

   always @(posedge clk) if (in_valid && in_ready) accept_cnt++;

   function automatic logic [15:0] pack(input int l0, input int l1, input int l2, input int l3);
      logic [3:0] a, b, c, d;
      a = 4'(l0); b = 4'(l1); c = 4'(l2); d = 4'(l3);
      return {d, c, b, a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int n);
      num_groups = LEN_BW'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; num_groups = '0; in_valid = 1'b0;
      x_in = '0; w_in = '0; result_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({busy, in_ready, result_valid} !== 3'b000 || result !== 16'd0 || psum_out !== 16'd0 ||
          x_out !== 16'd0 || w_out !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%0b in_ready=%0b rv=%0b result=%0d psum=%0d x=%h w=%h required all 0",
                  busy, in_ready, result_valid, result, psum_out, x_out, w_out);
      end
   endtask

   task automatic test_single();
      start_job(1);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_run: busy=%0b in_ready=%0b required 1 1", busy, in_ready);
      end
      in_valid = 1'b1; x_in = pack(1, 2, 3, 4); w_in = pack(1, 1, 1, 1);
      tick();
      in_valid = 1'b0;
      checks++;
      if (x_out !== pack(1, 2, 3, 4) || in_ready !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_reg: x_out=%h in_ready=%0b rv=%0b required %h 0 0",
                  x_out, in_ready, result_valid, pack(1, 2, 3, 4));
      end
      tick();
      checks++;
      if (result_valid !== 1'b1 || result !== 16'd10) begin
         errors++;
         $display("FAIL single_result: rv=%0b result=%0d required 1 10", result_valid, result);
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_release: rv=%0b busy=%0b required 0 0", result_valid, busy);
      end
   endtask

   task automatic set_group(input int k);
      case (k)
         0: begin x_in = pack(1, 1, 1, 2); w_in = pack(1, 1, 1, 1); end
         1: begin x_in = pack(5, 0, 0, 0); w_in = pack(1, 1, 1, 1); end
         default: begin x_in = pack(1, 2, 0, 0); w_in = pack(1, 2, 0, 0); end
      endcase
   endtask

   task automatic test_back_to_back();
      int base;
      start_job(3);
      base = accept_cnt;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_group(k);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_%0d: in_ready=%0b required 1", k, in_ready);
         end
         tick();
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ready_after: in_ready=%0b required 0", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (result_valid !== 1'b1 || result !== 16'd15 || accept_cnt - base !== 3) begin
         errors++;
         $display("FAIL b2b_result: rv=%0b result=%0d accepts=%0d required 1 15 3",
                  result_valid, result, accept_cnt - base);
      end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
   endtask

   task automatic test_bubbles();
      start_job(3);
      for (int k = 0; k < 3; k++) begin
         set_group(k);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         for (int g = 0; g < 2; g++) begin
            tick();
            if (k < 2) begin
               checks++;
               if (psum_out !== 16'(5 * (k + 1)) || result_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL bubble_acc_%0d_%0d: psum=%0d rv=%0b required %0d 0",
                           k, g, psum_out, result_valid, 5 * (k + 1));
               end
            end
         end
      end
      checks++;
      if (result_valid !== 1'b1 || result !== 16'd15 || psum_out !== 16'd15) begin
         errors++;
         $display("FAIL bubble_result: rv=%0b result=%0d psum=%0d required 1 15 15",
                  result_valid, result, psum_out);
      end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
   endtask

   task automatic test_zero_len();
      start_job(0);
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (result_valid !== 1'b1 || result !== 16'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_%0d: rv=%0b result=%0d in_ready=%0b busy=%0b required 1 0 0 1",
                     c, result_valid, result, in_ready, busy);
         end
         tick();
      end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      start_job(1);
      in_valid = 1'b1; x_in = pack(1, 2, 3, 4); w_in = pack(1, 1, 1, 1);
      tick();
      in_valid = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin num_groups = 8'd5; start = 1'b1; end
         tick();
         start = 1'b0;
         checks++;
         if (result_valid !== 1'b1 || result !== 16'd10 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: rv=%0b result=%0d busy=%0b in_ready=%0b required 1 10 1 0",
                     c, result_valid, result, busy, in_ready);
         end
      end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: rv=%0b busy=%0b required 0 0", result_valid, busy);
      end
   endtask

   task automatic test_reset_mid_job();
      start_job(4);
      in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin set_group(k); tick(); end
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({busy, in_ready, result_valid} !== 3'b000 || result !== 16'd0 || psum_out !== 16'd0 ||
          x_out !== 16'd0 || w_out !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: busy=%0b in_ready=%0b rv=%0b result=%0d psum=%0d x=%h w=%h required all 0",
                  busy, in_ready, result_valid, result, psum_out, x_out, w_out);
      end
      start_job(1);
      in_valid = 1'b1; x_in = pack(7, 0, 0, 0); w_in = pack(1, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (result_valid !== 1'b1 || result !== 16'd7) begin
         errors++;
         $display("FAIL post_reset_job: rv=%0b result=%0d required 1 7", result_valid, result);
      end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
   endtask

   task automatic test_max_len();
      int stalls;
      int base;
      stalls = 0;
      start_job(255);
      base = accept_cnt;
      in_valid = 1'b1; x_in = pack(15, 15, 15, 15); w_in = pack(15, 15, 15, 15);
      for (int k = 0; k < 255; k++) begin
         if (in_ready !== 1'b1) stalls++;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (stalls != 0 || accept_cnt - base !== 255 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL max_len_accepts: stalls=%0d accepts=%0d in_ready=%0b required 0 255 0",
                  stalls, accept_cnt - base, in_ready);
      end
      tick();
      // 255 * 900 = 229500, modulo 65536 = 32892
      checks++;
      if (result_valid !== 1'b1 || result !== 16'd32892) begin
         errors++;
         $display("FAIL max_len_result: rv=%0b result=%0d required 1 32892", result_valid, result);
      end
      result_ready = 1'b1; tick(); result_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_bubbles();
      test_zero_len();
      test_backpressure();
      test_reset_mid_job();
      test_max_len();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
